// File: rtl/sirv_expl_axi_arb_defines.sv
// rtl/sirv_expl_axi_arb_defines.sv - shared encodings and widths for the two-master AXI arbiter
package sirv_expl_axi_arb_defines;

    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_DATA = 2'd2,
        WR_RESP = 2'd3
    } wr_state_e;

endpackage

// File: rtl/sirv_rr_arb2.sv
// rtl/sirv_rr_arb2.sv - two-request round-robin picker with a single-bit priority pointer
module sirv_rr_arb2
    import sirv_expl_axi_arb_defines::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic [1:0] served,
    output logic [1:0] gnt
);

    // ptr_q = 0 favours m0, 1 favours m1
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        // favour whichever master did not just finish, even if it won uncontested
        if (advance) begin
            ptr_d = served[0];
        end
        case (req)
            2'b11:   gnt = ptr_q ? GNT_M1 : GNT_M0;
            default: gnt = req;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sirv_expl_axi_arb2.sv
// rtl/sirv_expl_axi_arb2.sv - two-master to one-slave AXI arbiter, independent RR read and write paths
module sirv_expl_axi_arb2
    import sirv_expl_axi_arb_defines::*;
#(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m0_axi_arvalid,
    output logic               m0_axi_arready,
    input  logic [AW-1:0]      m0_axi_araddr,
    input  logic               m0_axi_arcache,
    input  logic               m0_axi_arprot,
    input  logic               m0_axi_arlock,
    input  logic [BURST_W-1:0] m0_axi_arburst,
    input  logic [LEN_W-1:0]   m0_axi_arlen,
    input  logic [SIZE_W-1:0]  m0_axi_arsize,
    output logic               m0_axi_rvalid,
    input  logic               m0_axi_rready,
    output logic [DW-1:0]      m0_axi_rdata,
    output logic [RESP_W-1:0]  m0_axi_rresp,
    output logic               m0_axi_rlast,
    input  logic               m0_axi_awvalid,
    output logic               m0_axi_awready,
    input  logic [AW-1:0]      m0_axi_awaddr,
    input  logic               m0_axi_awcache,
    input  logic               m0_axi_awprot,
    input  logic               m0_axi_awlock,
    input  logic [BURST_W-1:0] m0_axi_awburst,
    input  logic [LEN_W-1:0]   m0_axi_awlen,
    input  logic [SIZE_W-1:0]  m0_axi_awsize,
    input  logic               m0_axi_wvalid,
    output logic               m0_axi_wready,
    input  logic [DW-1:0]      m0_axi_wdata,
    input  logic [DW/8-1:0]    m0_axi_wstrb,
    input  logic               m0_axi_wlast,
    output logic               m0_axi_bvalid,
    input  logic               m0_axi_bready,
    output logic [RESP_W-1:0]  m0_axi_bresp,
    input  logic               m1_axi_arvalid,
    output logic               m1_axi_arready,
    input  logic [AW-1:0]      m1_axi_araddr,
    input  logic               m1_axi_arcache,
    input  logic               m1_axi_arprot,
    input  logic               m1_axi_arlock,
    input  logic [BURST_W-1:0] m1_axi_arburst,
    input  logic [LEN_W-1:0]   m1_axi_arlen,
    input  logic [SIZE_W-1:0]  m1_axi_arsize,
    output logic               m1_axi_rvalid,
    input  logic               m1_axi_rready,
    output logic [DW-1:0]      m1_axi_rdata,
    output logic [RESP_W-1:0]  m1_axi_rresp,
    output logic               m1_axi_rlast,
    input  logic               m1_axi_awvalid,
    output logic               m1_axi_awready,
    input  logic [AW-1:0]      m1_axi_awaddr,
    input  logic               m1_axi_awcache,
    input  logic               m1_axi_awprot,
    input  logic               m1_axi_awlock,
    input  logic [BURST_W-1:0] m1_axi_awburst,
    input  logic [LEN_W-1:0]   m1_axi_awlen,
    input  logic [SIZE_W-1:0]  m1_axi_awsize,
    input  logic               m1_axi_wvalid,
    output logic               m1_axi_wready,
    input  logic [DW-1:0]      m1_axi_wdata,
    input  logic [DW/8-1:0]    m1_axi_wstrb,
    input  logic               m1_axi_wlast,
    output logic               m1_axi_bvalid,
    input  logic               m1_axi_bready,
    output logic [RESP_W-1:0]  m1_axi_bresp,
    output logic               s_axi_arvalid,
    input  logic               s_axi_arready,
    output logic [AW-1:0]      s_axi_araddr,
    output logic               s_axi_arcache,
    output logic               s_axi_arprot,
    output logic               s_axi_arlock,
    output logic [BURST_W-1:0] s_axi_arburst,
    output logic [LEN_W-1:0]   s_axi_arlen,
    output logic [SIZE_W-1:0]  s_axi_arsize,
    input  logic               s_axi_rvalid,
    output logic               s_axi_rready,
    input  logic [DW-1:0]      s_axi_rdata,
    input  logic [RESP_W-1:0]  s_axi_rresp,
    input  logic               s_axi_rlast,
    output logic               s_axi_awvalid,
    input  logic               s_axi_awready,
    output logic [AW-1:0]      s_axi_awaddr,
    output logic               s_axi_awcache,
    output logic               s_axi_awprot,
    output logic               s_axi_awlock,
    output logic [BURST_W-1:0] s_axi_awburst,
    output logic [LEN_W-1:0]   s_axi_awlen,
    output logic [SIZE_W-1:0]  s_axi_awsize,
    output logic               s_axi_wvalid,
    input  logic               s_axi_wready,
    output logic [DW-1:0]      s_axi_wdata,
    output logic [DW/8-1:0]    s_axi_wstrb,
    output logic               s_axi_wlast,
    input  logic               s_axi_bvalid,
    output logic               s_axi_bready,
    input  logic [RESP_W-1:0]  s_axi_bresp,
    output logic [1:0]         rd_gnt,
    output logic [1:0]         wr_gnt
);

    localparam int AX_W = AW + 3 + BURST_W + LEN_W + SIZE_W;
    localparam int WP_W = DW + DW/8 + 1;
    localparam int RP_W = DW + RESP_W + 1;

    // Per-master views packed so one registered-grant mux serves every field
    logic [AX_W-1:0] ar_pld [2];
    logic [AX_W-1:0] aw_pld [2];
    logic [WP_W-1:0] w_pld  [2];
    logic [RP_W-1:0] r_pld;
    logic [1:0]      arvalid, awvalid, wvalid, rready, bready;

    assign ar_pld[0] = {m0_axi_araddr, m0_axi_arcache, m0_axi_arprot, m0_axi_arlock,
                        m0_axi_arburst, m0_axi_arlen, m0_axi_arsize};
    assign ar_pld[1] = {m1_axi_araddr, m1_axi_arcache, m1_axi_arprot, m1_axi_arlock,
                        m1_axi_arburst, m1_axi_arlen, m1_axi_arsize};
    assign aw_pld[0] = {m0_axi_awaddr, m0_axi_awcache, m0_axi_awprot, m0_axi_awlock,
                        m0_axi_awburst, m0_axi_awlen, m0_axi_awsize};
    assign aw_pld[1] = {m1_axi_awaddr, m1_axi_awcache, m1_axi_awprot, m1_axi_awlock,
                        m1_axi_awburst, m1_axi_awlen, m1_axi_awsize};
    assign w_pld[0]  = {m0_axi_wdata, m0_axi_wstrb, m0_axi_wlast};
    assign w_pld[1]  = {m1_axi_wdata, m1_axi_wstrb, m1_axi_wlast};
    assign r_pld     = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
    assign arvalid   = {m1_axi_arvalid, m0_axi_arvalid};
    assign awvalid   = {m1_axi_awvalid, m0_axi_awvalid};
    assign wvalid    = {m1_axi_wvalid, m0_axi_wvalid};
    assign rready    = {m1_axi_rready, m0_axi_rready};
    assign bready    = {m1_axi_bready, m0_axi_bready};

    rd_state_e  rd_state_q, rd_state_d;
    wr_state_e  wr_state_q, wr_state_d;
    logic [1:0] rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d, rd_pick, wr_pick;
    logic       rd_adv, wr_adv;

    sirv_rr_arb2 u_rd_arb (.clk, .rst, .req(arvalid), .advance(rd_adv), .served(rd_gnt_q), .gnt(rd_pick));
    sirv_rr_arb2 u_wr_arb (.clk, .rst, .req(awvalid), .advance(wr_adv), .served(wr_gnt_q), .gnt(wr_pick));

    logic rd_sel, wr_sel, ar_act, r_act, aw_act, w_act, b_act;
    assign rd_sel = rd_gnt_q[1];
    assign wr_sel = wr_gnt_q[1];
    assign ar_act = (rd_state_q == RD_ADDR);
    assign r_act  = (rd_state_q == RD_DATA);
    assign aw_act = (wr_state_q == WR_ADDR);
    assign w_act  = (wr_state_q == WR_DATA);
    assign b_act  = (wr_state_q == WR_RESP);

    assign s_axi_arvalid = ar_act & arvalid[rd_sel];
    assign {s_axi_araddr, s_axi_arcache, s_axi_arprot, s_axi_arlock,
            s_axi_arburst, s_axi_arlen, s_axi_arsize} = ar_act ? ar_pld[rd_sel] : '0;
    assign m0_axi_arready = ar_act & rd_gnt_q[0] & s_axi_arready;
    assign m1_axi_arready = ar_act & rd_gnt_q[1] & s_axi_arready;

    assign s_axi_rready  = r_act & rready[rd_sel];
    assign m0_axi_rvalid = r_act & rd_gnt_q[0] & s_axi_rvalid;
    assign m1_axi_rvalid = r_act & rd_gnt_q[1] & s_axi_rvalid;
    assign {m0_axi_rdata, m0_axi_rresp, m0_axi_rlast} = (r_act & rd_gnt_q[0]) ? r_pld : '0;
    assign {m1_axi_rdata, m1_axi_rresp, m1_axi_rlast} = (r_act & rd_gnt_q[1]) ? r_pld : '0;

    assign s_axi_awvalid = aw_act & awvalid[wr_sel];
    assign {s_axi_awaddr, s_axi_awcache, s_axi_awprot, s_axi_awlock,
            s_axi_awburst, s_axi_awlen, s_axi_awsize} = aw_act ? aw_pld[wr_sel] : '0;
    assign m0_axi_awready = aw_act & wr_gnt_q[0] & s_axi_awready;
    assign m1_axi_awready = aw_act & wr_gnt_q[1] & s_axi_awready;

    // W is only opened after the AW handshake, so early wvalid just waits
    assign s_axi_wvalid = w_act & wvalid[wr_sel];
    assign {s_axi_wdata, s_axi_wstrb, s_axi_wlast} = w_act ? w_pld[wr_sel] : '0;
    assign m0_axi_wready = w_act & wr_gnt_q[0] & s_axi_wready;
    assign m1_axi_wready = w_act & wr_gnt_q[1] & s_axi_wready;

    assign s_axi_bready  = b_act & bready[wr_sel];
    assign m0_axi_bvalid = b_act & wr_gnt_q[0] & s_axi_bvalid;
    assign m1_axi_bvalid = b_act & wr_gnt_q[1] & s_axi_bvalid;
    assign m0_axi_bresp  = (b_act & wr_gnt_q[0]) ? s_axi_bresp : '0;
    assign m1_axi_bresp  = (b_act & wr_gnt_q[1]) ? s_axi_bresp : '0;

    assign rd_gnt = rd_gnt_q;
    assign wr_gnt = wr_gnt_q;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_gnt_d   = rd_gnt_q;
        rd_adv     = 1'b0;
        case (rd_state_q)
            RD_IDLE: if (|arvalid) begin
                rd_gnt_d   = rd_pick;
                rd_state_d = RD_ADDR;
            end
            RD_ADDR: if (s_axi_arvalid && s_axi_arready) rd_state_d = RD_DATA;
            RD_DATA: if (s_axi_rvalid && s_axi_rready && s_axi_rlast) begin
                rd_state_d = RD_IDLE;
                rd_gnt_d   = GNT_NONE;
                rd_adv     = 1'b1;
            end
            default: begin
                rd_state_d = RD_IDLE;
                rd_gnt_d   = GNT_NONE;
            end
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_gnt_d   = wr_gnt_q;
        wr_adv     = 1'b0;
        case (wr_state_q)
            WR_IDLE: if (|awvalid) begin
                wr_gnt_d   = wr_pick;
                wr_state_d = WR_ADDR;
            end
            WR_ADDR: if (s_axi_awvalid && s_axi_awready) wr_state_d = WR_DATA;
            WR_DATA: if (s_axi_wvalid && s_axi_wready && s_axi_wlast) wr_state_d = WR_RESP;
            WR_RESP: if (s_axi_bvalid && s_axi_bready) begin
                wr_state_d = WR_IDLE;
                wr_gnt_d   = GNT_NONE;
                wr_adv     = 1'b1;
            end
            default: begin
                wr_state_d = WR_IDLE;
                wr_gnt_d   = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            wr_state_q <= WR_IDLE;
            rd_gnt_q   <= GNT_NONE;
            wr_gnt_q   <= GNT_NONE;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_gnt_q   <= wr_gnt_d;
        end
    end

endmodule
